// File: rtl/demux_tdm_1a4_bus_if.sv
// Bus bundle for the TDM 1-to-4 demultiplexer: serial lane input side plus the
// rebuilt parallel frame outputs. The DUT uses the slave modport, the source uses master.
interface demux_tdm_1a4_bus_if #(
  parameter int ANCHO = 8
);
  logic [ANCHO-1:0] din;
  logic             din_valid;
  logic             frame_start;
  logic [1:0]       S;
  logic [ANCHO-1:0] Q0;
  logic [ANCHO-1:0] Q1;
  logic [ANCHO-1:0] Q2;
  logic [ANCHO-1:0] Q3;
  logic             frame_valid;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_start,
    input  S, Q0, Q1, Q2, Q3, frame_valid, sync_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output S, Q0, Q1, Q2, Q3, frame_valid, sync_err
  );
endinterface

// File: rtl/demux_tdm_1a4_bus.sv
// Rebuilds four parallel lanes from a round-robin TDM stream (lane 0 flagged by frame_start).
// Optional sticky resync detection is enabled by defining DEMUX_SYNC_ERR_EN.
module demux_tdm_1a4_bus #(
  parameter int ANCHO = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_tdm_1a4_bus_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [ANCHO-1:0] sh0_q, sh0_d;
  logic [ANCHO-1:0] sh1_q, sh1_d;
  logic [ANCHO-1:0] sh2_q, sh2_d;
  logic [ANCHO-1:0] q0_q, q0_d;
  logic [ANCHO-1:0] q1_q, q1_d;
  logic [ANCHO-1:0] q2_q, q2_d;
  logic [ANCHO-1:0] q3_q, q3_d;
  logic             fv_q, fv_d;
`ifdef DEMUX_SYNC_ERR_EN
  logic             serr_q, serr_d;
`endif

  // Next-state logic: lanes 0..2 park in shadows so Q0..Q3 only ever change together.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    q3_d    = q3_q;
    fv_d    = 1'b0;
`ifdef DEMUX_SYNC_ERR_EN
    serr_d  = serr_q;
`endif
    if (bus.din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            sh0_d   = bus.din;
            s_d     = 2'd1;
            state_d = ST_RECV;
          end else begin
            s_d     = 2'd0;
          end
        end
        ST_RECV: begin
          if (bus.frame_start) begin
            // Resync: the partial frame is dropped and this beat becomes lane 0.
            sh0_d = bus.din;
            s_d   = 2'd1;
`ifdef DEMUX_SYNC_ERR_EN
            serr_d = 1'b1;
`endif
          end else begin
            case (s_q)
              2'd1: begin
                sh1_d = bus.din;
                s_d   = 2'd2;
              end
              2'd2: begin
                sh2_d = bus.din;
                s_d   = 2'd3;
              end
              2'd3: begin
                q0_d    = sh0_q;
                q1_d    = sh1_q;
                q2_d    = sh2_q;
                q3_d    = bus.din;
                fv_d    = 1'b1;
                s_d     = 2'd0;
                state_d = ST_IDLE;
              end
              default: begin
                s_d     = 2'd0;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
        default: begin
          s_d     = 2'd0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      fv_d = 1'b0;
    end
  end

  // Frame state, shadows and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      q3_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      fv_q    <= fv_d;
    end
  end

`ifdef DEMUX_SYNC_ERR_EN
  // Sticky resync flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serr_q <= 1'b0;
    end else begin
      serr_q <= serr_d;
    end
  end

  assign bus.sync_err = serr_q;
`else
  assign bus.sync_err = 1'b0;
`endif

  assign bus.S           = s_q;
  assign bus.Q0          = q0_q;
  assign bus.Q1          = q1_q;
  assign bus.Q2          = q2_q;
  assign bus.Q3          = q3_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_demux_tdm_1a4_bus.sv
// Directed scoreboard bench for demux_tdm_1a4_bus: three instances (ANCHO 8, 4, 16) fed in lockstep.
// sync_err expectation follows DEMUX_SYNC_ERR_EN.
module tb_demux_tdm_1a4_bus;

`ifdef DEMUX_SYNC_ERR_EN
  localparam logic SERR_EN = 1'b1;
`else
  localparam logic SERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  demux_tdm_1a4_bus_if #(.ANCHO(8))  b8  ();
  demux_tdm_1a4_bus_if #(.ANCHO(4))  b4  ();
  demux_tdm_1a4_bus_if #(.ANCHO(16)) b16 ();

  demux_tdm_1a4_bus #(.ANCHO(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  demux_tdm_1a4_bus #(.ANCHO(4))  u4  (.clk(clk), .rst(rst), .bus(b4.slave));
  demux_tdm_1a4_bus #(.ANCHO(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int checks = 0;
  int errors = 0;
  int n_fv8 = 0, n_fv4 = 0, n_fv16 = 0;
  int n_push = 0;

  logic [31:0] sb8[$];
  logic [15:0] sb4[$];
  logic [63:0] sb16[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push3(input logic [31:0] e8, input logic [15:0] e4, input logic [63:0] e16);
    sb8.push_back(e8);
    sb4.push_back(e4);
    sb16.push_back(e16);
    n_push++;
  endtask

  // Narrow lanes take the low nibble, wide lanes carry {~d, d}.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    push3({a, b, c, d}, {a[3:0], b[3:0], c[3:0], d[3:0]}, {~a, a, ~b, b, ~c, c, ~d, d});
  endtask

  task automatic beat3(input logic [7:0] d8, input logic [3:0] d4, input logic [15:0] d16,
                       input logic fs, input logic [1:0] es);
    @(negedge clk);
    b8.din = d8;   b8.frame_start = fs;  b8.din_valid = 1'b1;
    b4.din = d4;   b4.frame_start = fs;  b4.din_valid = 1'b1;
    b16.din = d16; b16.frame_start = fs; b16.din_valid = 1'b1;
    @(posedge clk);
    #1;
    check_val("S8",  {62'd0, b8.S},  {62'd0, es});
    check_val("S4",  {62'd0, b4.S},  {62'd0, es});
    check_val("S16", {62'd0, b16.S}, {62'd0, es});
  endtask

  task automatic beat(input logic [7:0] d, input logic fs, input logic [1:0] es);
    beat3(d, d[3:0], {~d, d}, fs, es);
  endtask

  // Idle edges carry junk data and frame_start that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b8.din_valid = 1'b0;  b8.din = 8'($urandom);   b8.frame_start = 1'($urandom);
      b4.din_valid = 1'b0;  b4.din = 4'($urandom);   b4.frame_start = 1'($urandom);
      b16.din_valid = 1'b0; b16.din = 16'($urandom); b16.frame_start = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard side: every frame_valid pulse must match the oldest pushed frame.
  always @(posedge clk) begin
    #1;
    if (b8.frame_valid === 1'b1) begin
      n_fv8++;
      checks++;
      assert (sb8.size() > 0) else begin
        errors++;
        $error("FAIL fv8_unexpected observed frame %h expected no frame", {b8.Q0, b8.Q1, b8.Q2, b8.Q3});
      end
      if (sb8.size() > 0) check_val("frame8", {32'd0, b8.Q0, b8.Q1, b8.Q2, b8.Q3}, {32'd0, sb8.pop_front()});
    end
    if (b4.frame_valid === 1'b1) begin
      n_fv4++;
      checks++;
      assert (sb4.size() > 0) else begin
        errors++;
        $error("FAIL fv4_unexpected observed frame %h expected no frame", {b4.Q0, b4.Q1, b4.Q2, b4.Q3});
      end
      if (sb4.size() > 0) check_val("frame4", {48'd0, b4.Q0, b4.Q1, b4.Q2, b4.Q3}, {48'd0, sb4.pop_front()});
    end
    if (b16.frame_valid === 1'b1) begin
      n_fv16++;
      checks++;
      assert (sb16.size() > 0) else begin
        errors++;
        $error("FAIL fv16_unexpected observed frame %h expected no frame", {b16.Q0, b16.Q1, b16.Q2, b16.Q3});
      end
      if (sb16.size() > 0) check_val("frame16", {b16.Q0, b16.Q1, b16.Q2, b16.Q3}, sb16.pop_front());
    end
  end

  initial begin
    logic [7:0]  v8  [4];
    logic [3:0]  v4  [4];
    logic [15:0] v16 [4];
    rst = 1'b1;
    b8.din = 8'd0;   b8.din_valid = 1'b0;  b8.frame_start = 1'b0;
    b4.din = 4'd0;   b4.din_valid = 1'b0;  b4.frame_start = 1'b0;
    b16.din = 16'd0; b16.din_valid = 1'b0; b16.frame_start = 1'b0;
    #12;
    check_val("rst_Q8",   {32'd0, b8.Q0, b8.Q1, b8.Q2, b8.Q3}, 64'd0);
    check_val("rst_S8",   {62'd0, b8.S}, 64'd0);
    check_val("rst_fv8",  {63'd0, b8.frame_valid}, 64'd0);
    check_val("rst_serr", {63'd0, b8.sync_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contiguous frame.
    push(8'd10, 8'd20, 8'd30, 8'd40);
    beat(8'd10, 1'b1, 2'd1);
    beat(8'd20, 1'b0, 2'd2);
    beat(8'd30, 1'b0, 2'd3);
    beat(8'd40, 1'b0, 2'd0);
    check_val("fv8_after_40", {63'd0, b8.frame_valid}, 64'd1);
    idle(1);
    check_val("fv8_one_cycle", {63'd0, b8.frame_valid}, 64'd0);
    check_val("hold_Q8", {32'd0, b8.Q0, b8.Q1, b8.Q2, b8.Q3}, {32'd0, 8'd10, 8'd20, 8'd30, 8'd40});

    // Same frame with three idle edges between beats.
    push(8'd10, 8'd20, 8'd30, 8'd40);
    beat(8'd10, 1'b1, 2'd1); idle(3);
    check_val("gap_S8", {62'd0, b8.S}, 64'd1);
    beat(8'd20, 1'b0, 2'd2); idle(3);
    beat(8'd30, 1'b0, 2'd3); idle(3);
    check_val("gap_fv8", {63'd0, b8.frame_valid}, 64'd0);
    beat(8'd40, 1'b0, 2'd0);
    check_val("gap_fv8_end", {63'd0, b8.frame_valid}, 64'd1);
    idle(2);

    // Hunting: beats without frame_start are dropped.
    beat(8'd5, 1'b0, 2'd0);
    beat(8'd6, 1'b0, 2'd0);
    push(8'd11, 8'd21, 8'd31, 8'd41);
    beat(8'd11, 1'b1, 2'd1);
    beat(8'd21, 1'b0, 2'd2);
    beat(8'd31, 1'b0, 2'd3);
    beat(8'd41, 1'b0, 2'd0);
    idle(1);
    check_val("hunt_serr", {63'd0, b8.sync_err}, 64'd0);

    // Resync mid-frame.
    beat(8'd10, 1'b1, 2'd1);
    beat(8'd20, 1'b0, 2'd2);
    push(8'd50, 8'd60, 8'd70, 8'd80);
    beat(8'd50, 1'b1, 2'd1);
    beat(8'd60, 1'b0, 2'd2);
    beat(8'd70, 1'b0, 2'd3);
    beat(8'd80, 1'b0, 2'd0);
    idle(1);
    check_val("resync_serr8",  {63'd0, b8.sync_err},  {63'd0, SERR_EN});
    check_val("resync_serr16", {63'd0, b16.sync_err}, {63'd0, SERR_EN});

    // Asynchronous reset mid-frame, checked before any clock edge.
    beat(8'd10, 1'b1, 2'd1);
    beat(8'd20, 1'b0, 2'd2);
    @(negedge clk);
    b8.din_valid = 1'b0; b4.din_valid = 1'b0; b16.din_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("arst_Q8",   {32'd0, b8.Q0, b8.Q1, b8.Q2, b8.Q3}, 64'd0);
    check_val("arst_Q16",  {b16.Q0, b16.Q1, b16.Q2, b16.Q3}, 64'd0);
    check_val("arst_S8",   {62'd0, b8.S}, 64'd0);
    check_val("arst_serr", {63'd0, b8.sync_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(8'd1, 8'd2, 8'd3, 8'd4);
    beat(8'd1, 1'b1, 2'd1);
    beat(8'd2, 1'b0, 2'd2);
    beat(8'd3, 1'b0, 2'd3);
    beat(8'd4, 1'b0, 2'd0);
    idle(1);
    check_val("post_rst_serr", {63'd0, b8.sync_err}, 64'd0);

    // Back-to-back frames, independent data per instance.
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) begin
        v8[l]  = 8'($urandom);
        v16[l] = 16'($urandom);
      end
      v4[0] = 4'd0; v4[1] = 4'd1; v4[2] = 4'd5; v4[3] = 4'd6;
      push3({v8[0], v8[1], v8[2], v8[3]}, {v4[0], v4[1], v4[2], v4[3]},
            {v16[0], v16[1], v16[2], v16[3]});
      beat3(v8[0], v4[0], v16[0], 1'b1, 2'd1);
      beat3(v8[1], v4[1], v16[1], 1'b0, 2'd2);
      beat3(v8[2], v4[2], v16[2], 1'b0, 2'd3);
      beat3(v8[3], v4[3], v16[3], 1'b0, 2'd0);
      check_val("b2b_fv4", {63'd0, b4.frame_valid}, 64'd1);
    end
    idle(2);

    check_val("sb8_drained",  64'(sb8.size()),  64'd0);
    check_val("sb4_drained",  64'(sb4.size()),  64'd0);
    check_val("sb16_drained", 64'(sb16.size()), 64'd0);
    check_val("n_fv8",  64'(n_fv8),  64'(n_push));
    check_val("n_fv4",  64'(n_fv4),  64'(n_push));
    check_val("n_fv16", 64'(n_fv16), 64'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
